// File: rtl/md_pad_pkg.sv
// Shared constants and types for the Mega Drive pad emulator: pin map,
// TH-pulse counter type and its two meaningful values.
package md_pad_pkg;

  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_TL    = 4;
  localparam int PIN_TR    = 5;
  localparam int PIN_TH    = 6;

  typedef logic [2:0] cnt_t;

  localparam cnt_t CNT_ID  = 3'd3;
  localparam cnt_t CNT_MAX = 3'd4;

  // Saturating step of the TH-pulse counter; it never wraps past CNT_MAX.
  function automatic cnt_t cnt_inc(input cnt_t c);
    return (c >= CNT_MAX) ? CNT_MAX : cnt_t'(c + 3'd1);
  endfunction

endpackage

// File: rtl/md_pad_timer.sv
// Inactivity timer for the 6-button sequence: counts up to TIMEOUT and holds,
// raising expire while parked at the terminal count.
module md_pad_timer #(
  parameter int TIMEOUT = 80000,
  parameter int TW      = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TW-1:0] TERM = TW'(TIMEOUT);

  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (clear) begin
      tmr_d = '0;
    end else if (enable && (tmr_q != TERM)) begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign expire = (tmr_q == TERM);

endmodule

// File: rtl/md_pad_emu.sv
// One Mega Drive 3/6-button pad: decodes TH, tracks the TH-pulse counter with
// its inactivity timeout and presents a registered active-low pin image.
module md_pad_emu
  import md_pad_pkg::*;
#(
  parameter int TIMEOUT = 80000,
  parameter int TW      = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MODE,
  input  logic       P_UP,
  input  logic       P_DOWN,
  input  logic       P_LEFT,
  input  logic       P_RIGHT,
  input  logic       P_A,
  input  logic       P_B,
  input  logic       P_C,
  input  logic       P_START,
  input  logic       P_MODE,
  input  logic       P_X,
  input  logic       P_Y,
  input  logic       P_Z,
  input  logic [6:0] port_in,
  input  logic [6:0] port_dir,
  output logic [6:0] port_out
);

  logic       th;
  logic       th_q;
  logic       fall;
  logic       expire;
  cnt_t       cnt_q;
  cnt_t       cnt_d;
  logic [6:0] port_out_q;
  logic [6:0] port_out_d;

  // Only TH is read from the console; the other console levels do not affect the pad.
  logic unused_pins;
  assign unused_pins = ^{port_in[5:0], port_dir[5:0]};

  assign th   = port_dir[PIN_TH] | port_in[PIN_TH];
  assign fall = th_q & ~th;

  md_pad_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (fall),
    .enable (1'b1),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q       <= 1'b1;
      cnt_q      <= '0;
      port_out_q <= 7'h7F;
    end else begin
      th_q       <= th;
      cnt_q      <= cnt_d;
      port_out_q <= port_out_d;
    end
  end

  // A falling edge outranks a simultaneous timeout.
  always_comb begin
    cnt_d = cnt_q;
    if (!MODE) begin
      cnt_d = '0;
    end else if (fall) begin
      cnt_d = cnt_inc(cnt_q);
    end else if (expire) begin
      cnt_d = '0;
    end
  end

  // Phase mux uses the updated count so the ID nibble follows its edge by one clock.
  always_comb begin
    port_out_d         = 7'h7F;
    port_out_d[PIN_TH] = th;
    if (th) begin
      port_out_d[PIN_TR] = ~P_C;
      port_out_d[PIN_TL] = ~P_B;
      if (cnt_d == CNT_ID) begin
        port_out_d[PIN_RIGHT] = ~P_MODE;
        port_out_d[PIN_LEFT]  = ~P_X;
        port_out_d[PIN_DOWN]  = ~P_Y;
        port_out_d[PIN_UP]    = ~P_Z;
      end else begin
        port_out_d[PIN_RIGHT] = ~P_RIGHT;
        port_out_d[PIN_LEFT]  = ~P_LEFT;
        port_out_d[PIN_DOWN]  = ~P_DOWN;
        port_out_d[PIN_UP]    = ~P_UP;
      end
    end else begin
      port_out_d[PIN_TR] = ~P_START;
      port_out_d[PIN_TL] = ~P_A;
      if (cnt_d == CNT_ID) begin
        port_out_d[PIN_RIGHT] = 1'b0;
        port_out_d[PIN_LEFT]  = 1'b0;
        port_out_d[PIN_DOWN]  = 1'b0;
        port_out_d[PIN_UP]    = 1'b0;
      end else if (cnt_d == CNT_MAX) begin
        port_out_d[PIN_RIGHT] = 1'b1;
        port_out_d[PIN_LEFT]  = 1'b1;
        port_out_d[PIN_DOWN]  = 1'b1;
        port_out_d[PIN_UP]    = 1'b1;
      end else begin
        port_out_d[PIN_RIGHT] = 1'b0;
        port_out_d[PIN_LEFT]  = 1'b0;
        port_out_d[PIN_DOWN]  = ~P_DOWN;
        port_out_d[PIN_UP]    = ~P_UP;
      end
    end
  end

  assign port_out = port_out_q;

endmodule

// File: tb/tb_md_pad_emu.sv
// Self-checking bench for md_pad_emu: directed TH sequences plus randomized
// traffic compared against a cycle-count based reference model.
module tb_md_pad_emu;

  localparam int TO = 20;
  localparam int TWD = 5;

  logic       clk;
  logic       reset;
  logic       mode;
  logic       p_up, p_down, p_left, p_right, p_a, p_b, p_c, p_start;
  logic       p_mode, p_x, p_y, p_z;
  logic [6:0] port_in;
  logic [6:0] port_dir;
  logic [6:0] port_out;

  int         n_checks;
  int         n_fail;

  // Reference model state: edges since last clear, clock of last tmr clear.
  int         cyc;
  int         m_edges;
  int         m_last;
  logic       m_thp;
  logic [6:0] m_exp;

  md_pad_emu #(
    .TIMEOUT (TO),
    .TW      (TWD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MODE     (mode),
    .P_UP     (p_up),
    .P_DOWN   (p_down),
    .P_LEFT   (p_left),
    .P_RIGHT  (p_right),
    .P_A      (p_a),
    .P_B      (p_b),
    .P_C      (p_c),
    .P_START  (p_start),
    .P_MODE   (p_mode),
    .P_X      (p_x),
    .P_Y      (p_y),
    .P_Z      (p_z),
    .port_in  (port_in),
    .port_dir (port_dir),
    .port_out (port_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pad_image(input logic th, input int cnt);
    logic [6:0] r;
    r[6] = th;
    if (th) begin
      r[5] = !p_c;
      r[4] = !p_b;
      if (cnt == 3) r[3:0] = {!p_mode, !p_x, !p_y, !p_z};
      else          r[3:0] = {!p_right, !p_left, !p_down, !p_up};
    end else begin
      r[5] = !p_start;
      r[4] = !p_a;
      if (cnt == 3)      r[3:0] = 4'h0;
      else if (cnt == 4) r[3:0] = 4'hF;
      else               r[3:0] = {2'b00, !p_down, !p_up};
    end
    return r;
  endfunction

  // One clock: advance the model from the inputs in force, then settle.
  task automatic tick();
    logic th, fall, expire;
    @(posedge clk);
    cyc = cyc + 1;
    th = port_dir[6] | port_in[6];
    if (reset) begin
      m_thp   = 1'b1;
      m_edges = 0;
      m_last  = cyc;
      m_exp   = 7'h7F;
    end else begin
      fall   = m_thp && !th;
      expire = (cyc - m_last) >= TO + 1;
      if (fall) m_last = cyc;
      if (!mode)       m_edges = 0;
      else if (fall)   m_edges = m_edges + 1;
      else if (expire) m_edges = 0;
      m_thp = th;
      m_exp = pad_image(th, (m_edges > 4) ? 4 : m_edges);
    end
    #1;
  endtask

  task automatic set_th(input logic lvl);
    port_dir[6] = 1'b0;
    port_in[6]  = lvl;
  endtask

  task automatic clear_buttons();
    {p_up, p_down, p_left, p_right, p_a, p_b, p_c, p_start} = 8'h00;
    {p_mode, p_x, p_y, p_z} = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode = 1'b0;
    clear_buttons();
    port_in  = 7'h00;
    port_dir = 7'h7F;
    tick();
    tick();
    n_checks++;
    if (port_out !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_value: got %h want 7f", port_out);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (port_out !== 7'h7F) begin
        n_fail++;
        $display("FAIL idle_undriven: got %h want 7f", port_out);
      end
    end
    $display("test_reset: port_out=%h", port_out);
  endtask

  task automatic test_three_button();
    logic lvl;
    logic [6:0] want;
    mode = 1'b0;
    clear_buttons();
    p_up = 1'b1; p_a = 1'b1; p_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lvl = (i % 2 == 0);
      want = lvl ? 7'h7E : 7'h02;
      set_th(lvl);
      for (int k = 0; k < 2; k++) begin
        tick();
        n_checks++;
        if (port_out !== want || port_out !== m_exp) begin
          n_fail++;
          $display("FAIL three_button lvl%0d: got %h want %h", i, port_out, want);
        end
      end
      $display("three_button level %0d th=%0d port_out=%h", i, lvl, port_out);
    end
  endtask

  task automatic test_six_button();
    logic lvl;
    logic [6:0] want;
    set_th(1'b1);
    do_reset();
    mode = 1'b1;
    clear_buttons();
    p_x = 1'b1; p_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lvl = (i % 2 == 0);
      set_th(lvl);
      for (int k = 0; k < 2; k++) begin
        tick();
        want = m_exp;
        if (i == 5) want = 7'h30;
        if (i == 6) want = 7'h5B;
        if (i == 7) want = 7'h3F;
        n_checks++;
        if (port_out !== want || port_out !== m_exp) begin
          n_fail++;
          $display("FAIL six_button lvl%0d: got %h want %h", i, port_out, want);
        end
      end
      $display("six_button level %0d th=%0d port_out=%h", i, lvl, port_out);
    end
  endtask

  task automatic test_timeout();
    set_th(1'b1);
    do_reset();
    mode = 1'b1;
    clear_buttons();
    p_c = 1'b1; p_x = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_th(i % 2 == 0);
      tick();
      tick();
    end
    set_th(1'b1);
    tick();
    n_checks++;
    if (port_out !== 7'h5B) begin
      n_fail++;
      $display("FAIL timeout_extended: got %h want 5b", port_out);
    end
    for (int i = 0; i < TO + 2; i++) begin
      tick();
      n_checks++;
      if (port_out !== m_exp) begin
        n_fail++;
        $display("FAIL timeout_hold cyc%0d: got %h want %h", i, port_out, m_exp);
      end
    end
    n_checks++;
    if (port_out !== 7'h5F) begin
      n_fail++;
      $display("FAIL timeout_standard: got %h want 5f", port_out);
    end
    set_th(1'b0);
    tick();
    n_checks++;
    if (port_out !== 7'h33 || port_out !== m_exp) begin
      n_fail++;
      $display("FAIL timeout_next_low: got %h want 33", port_out);
    end
    $display("timeout: after expiry low phase port_out=%h", port_out);
  endtask

  task automatic test_reset_mid();
    set_th(1'b1);
    do_reset();
    mode = 1'b1;
    clear_buttons();
    for (int i = 0; i < 6; i++) begin
      set_th(i % 2 == 0);
      tick();
      tick();
    end
    n_checks++;
    if (port_out !== 7'h30) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %h want 30", port_out);
    end
    set_th(1'b0);
    reset = 1'b1;
    tick();
    n_checks++;
    if (port_out !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_mid_value: got %h want 7f", port_out);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (port_out !== 7'h33 || port_out !== m_exp) begin
      n_fail++;
      $display("FAIL reset_release_edge: got %h want 33", port_out);
    end
    $display("reset_mid: after release port_out=%h", port_out);
  endtask

  // Second edge after cnt=2 lands at tmr==TIMEOUT (late=0) or one clock later (late=1).
  task automatic test_edge_at_timeout(input int late);
    logic [6:0] want;
    want = (late != 0) ? 7'h33 : 7'h30;
    set_th(1'b1);
    do_reset();
    mode = 1'b1;
    clear_buttons();
    for (int i = 0; i < 3; i++) begin
      set_th(i % 2 == 0);
      tick();
      tick();
    end
    set_th(1'b0);
    tick();
    tick();
    set_th(1'b1);
    for (int i = 0; i < TO - 1 + late; i++) tick();
    set_th(1'b0);
    tick();
    n_checks++;
    if (port_out !== want || port_out !== m_exp) begin
      n_fail++;
      $display("FAIL edge_at_timeout late%0d: got %h want %h", late, port_out, want);
    end
    $display("edge_at_timeout late=%0d port_out=%h", late, port_out);
  endtask

  task automatic test_random();
    int hold;
    logic [11:0] b;
    for (int seg = 0; seg < 80; seg++) begin
      reset = ($urandom_range(0, 19) == 0);
      mode  = ($urandom_range(0, 7) != 0);
      b = 12'($urandom);
      {p_z, p_y, p_x, p_mode, p_start, p_c, p_b, p_a, p_right, p_left, p_down, p_up} = b;
      port_in[5:0]  = 6'($urandom);
      port_dir[5:0] = 6'($urandom);
      port_dir[6]   = ($urandom_range(0, 9) == 0);
      port_in[6]    = ~port_in[6];
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(1, 3);
      for (int k = 0; k < hold; k++) begin
        tick();
        n_checks++;
        if (port_out !== m_exp) begin
          n_fail++;
          $display("FAIL random seg%0d cyc%0d: got %h want %h", seg, k, port_out, m_exp);
        end
        reset = 1'b0;
      end
      $display("random seg %0d mode=%0d th=%0d hold=%0d port_out=%h", seg, mode,
               port_dir[6] | port_in[6], hold, port_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_edges  = 0;
    m_last   = 0;
    m_thp    = 1'b1;
    m_exp    = 7'h7F;
    test_reset();
    test_three_button();
    test_six_button();
    test_timeout();
    test_reset_mid();
    test_edge_at_timeout(0);
    test_edge_at_timeout(1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
